// File: rtl/game_master_fsm.sv
// Snake game master: sequences IDLE/PLAY/PAUSE/RESPAWN/WIN/LOSE, tracks lives and paces movement ticks.
// Optional macro GAME_AUTO_RESTART_EN: WIN/LOSE return to IDLE on their own after END_HOLD cycles.
`timescale 1ns/1ps

module game_master_fsm #(
   parameter int          SCORE_WIDTH    = 8,
   parameter int unsigned WIN_SCORE      = 10,
   parameter int unsigned LIVES          = 3,
   parameter int unsigned BASE_PERIOD    = 50_000_000,
   parameter int unsigned SPEED_STEP     = 2_000_000,
   parameter int unsigned MIN_PERIOD     = 10_000_000,
   parameter int unsigned RESPAWN_CYCLES = 100_000_000,
   parameter int unsigned END_HOLD       = 500_000_000
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic [SCORE_WIDTH-1:0] SCORE,
   input  logic                   BTNR,
   input  logic                   BTND,
   input  logic                   BTNL,
   input  logic                   BTNU,
   input  logic                   BTNC,
   input  logic                   COLLISION,
   output logic [2:0]             MSM_state,
   output logic [3:0]             LIVES_LEFT,
   output logic                   GAME_TICK,
   output logic                   SNAKE_RESET
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PLAY    = 3'd1,
      PAUSE   = 3'd2,
      RESPAWN = 3'd3,
      WIN     = 3'd4,
      LOSE    = 3'd5
   } state_t;

   localparam int unsigned MAX_AB  = (BASE_PERIOD > RESPAWN_CYCLES) ? BASE_PERIOD : RESPAWN_CYCLES;
   localparam int unsigned MAX_CNT = (MAX_AB > END_HOLD) ? MAX_AB : END_HOLD;
   localparam int          CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
   // Largest score for which BASE_PERIOD - SCORE*SPEED_STEP stays at or above the floor.
   localparam int unsigned STEP_LIMIT = (SPEED_STEP == 0 || BASE_PERIOD <= MIN_PERIOD) ? 0
                                        : (BASE_PERIOD - MIN_PERIOD) / SPEED_STEP;

   state_t             state;
   state_t             next_state;
   logic [4:0]         btn;
   logic [4:0]         btn_q;
   logic               armed;
   logic [4:0]         edges;
   logic               dir_edge;
   logic               pause_edge;
   logic [3:0]         lives;
   logic [CNT_W-1:0]   tick_cnt;
   logic [CNT_W-1:0]   hold_cnt;
   logic [31:0]        score_ext;
   logic [31:0]        period;
   logic               win_hit;
   logic               stay_play;
   logic               tick_due;
   logic               hold_active;
   logic               hold_done;

   // armed suppresses edges in the first cycle after reset, so a button held through reset is ignored.
   assign btn        = {BTNC, BTNU, BTNL, BTND, BTNR};
   assign edges      = btn & ~btn_q & {5{armed}};
   assign dir_edge   = |edges[3:0];
   assign pause_edge = edges[4];

   assign score_ext = 32'(SCORE);
   assign win_hit   = (score_ext >= WIN_SCORE);

   // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      period = BASE_PERIOD;
      if (BASE_PERIOD <= MIN_PERIOD) begin
         period = MIN_PERIOD;
      end else if (SPEED_STEP == 0) begin
         period = BASE_PERIOD;
      end else if (score_ext > STEP_LIMIT) begin
         period = MIN_PERIOD;
      end else begin
         period = BASE_PERIOD - score_ext * SPEED_STEP;
      end
   end

   always_comb begin
      hold_active = (state == RESPAWN);
      hold_done   = (state == RESPAWN) && (32'(hold_cnt) >= RESPAWN_CYCLES - 32'd1);
`ifdef GAME_AUTO_RESTART_EN
      if (state == WIN || state == LOSE) begin
         hold_active = 1'b1;
         hold_done   = (32'(hold_cnt) >= END_HOLD - 32'd1);
      end
`endif
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (dir_edge) next_state = PLAY;
         end
         PLAY: begin
            if (win_hit) begin
               next_state = WIN;
            end else if (COLLISION) begin
               next_state = (lives <= 4'd1) ? LOSE : RESPAWN;
            end else if (pause_edge) begin
               next_state = PAUSE;
            end
         end
         PAUSE: begin
            if (pause_edge) next_state = PLAY;
         end
         RESPAWN: begin
            if (hold_done) next_state = PLAY;
         end
         WIN, LOSE: begin
            if (pause_edge || hold_done) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign stay_play = (state == PLAY) && (next_state == PLAY);
   assign tick_due  = (32'(tick_cnt) >= period - 32'd1);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
         btn_q <= '0;
         armed <= 1'b0;
      end else begin
         state <= next_state;
         btn_q <= btn;
         armed <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         lives       <= 4'(LIVES);
         SNAKE_RESET <= 1'b0;
      end else begin
         if (next_state == IDLE) begin
            lives <= 4'(LIVES);
         end else if (state == PLAY && next_state == LOSE) begin
            lives <= 4'd0;
         end else if (state == PLAY && next_state == RESPAWN) begin
            lives <= lives - 4'd1;
         end
         SNAKE_RESET <= (state == IDLE && next_state == PLAY) ||
                        (state == PLAY && next_state == RESPAWN);
      end
   end

   // Tick counter advances only while PLAY persists; it is frozen through PAUSE and zeroed elsewhere.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         tick_cnt  <= '0;
         GAME_TICK <= 1'b0;
      end else begin
         GAME_TICK <= stay_play && tick_due;
         if (stay_play) begin
            tick_cnt <= tick_due ? '0 : tick_cnt + 1'b1;
         end else if (state != PLAY && state != PAUSE) begin
            tick_cnt <= '0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hold_cnt <= '0;
      end else if (next_state != state || !hold_active) begin
         hold_cnt <= '0;
      end else begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   assign MSM_state  = state;
   assign LIVES_LEFT = lives;

   tick_only_in_play : assert property (@(posedge CLK) disable iff (!RESET_N)
      GAME_TICK |-> (state == PLAY));
   snake_reset_on_entry : assert property (@(posedge CLK) disable iff (!RESET_N)
      SNAKE_RESET |-> (state == PLAY || state == RESPAWN));

endmodule
